// File: rtl/cifra_bloco_iterativa_if.sv
// Handshake/data bundle for cifra_bloco_iterativa.
// The rodada field exists only when RODADA_PARCIAL_EN is defined.
interface cifra_bloco_iterativa_if;
  logic         ent_valido;
  logic         ent_pronto;
  logic [127:0] bloco;
  logic [127:0] chave;
`ifdef RODADA_PARCIAL_EN
  logic [3:0]   rodada;
`endif
  logic         sai_valido;
  logic         sai_pronto;
  logic [127:0] saida;
  logic         ocupado;

`ifdef RODADA_PARCIAL_EN
  modport master (output ent_valido, bloco, chave, rodada, sai_pronto,
                  input  ent_pronto, sai_valido, saida, ocupado);
  modport slave  (input  ent_valido, bloco, chave, rodada, sai_pronto,
                  output ent_pronto, sai_valido, saida, ocupado);
`else
  modport master (output ent_valido, bloco, chave, sai_pronto,
                  input  ent_pronto, sai_valido, saida, ocupado);
  modport slave  (input  ent_valido, bloco, chave, sai_pronto,
                  output ent_pronto, sai_valido, saida, ocupado);
`endif
endinterface

// File: rtl/cifra_bloco_iterativa.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Optional RODADA_PARCIAL_EN adds the rodada input to stop after fewer rounds.
module cifra_bloco_iterativa #(
  parameter int ROUNDS = 10
) (
  input logic                    clk,
  input logic                    rst_n,
  cifra_bloco_iterativa_if.slave bus
);

  if (ROUNDS < 1 || ROUNDS > 10) begin : g_rounds_check
    $error("cifra_bloco_iterativa: ROUNDS must be in 1..10");
  end

  typedef enum logic [1:0] {OCIOSO, RODANDO, PRONTO} estado_t;

  estado_t      estado, estado_prox;
  logic [127:0] estado_reg, chave_reg, saida_reg;
  logic [127:0] sb, sr, mc, chave_nova, rodada_nova;
  logic [31:0]  t, k0, k1, k2, k3;
  logic [3:0]   contador, alvo, alvo_ent;
  logic         aceita, ultima;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = gmul(a, a);
    inv = sq;
    for (int unsigned k = 2; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // Key schedule step: RotWord/SubWord of the last word, chained XOR across the four words.
  assign t = {sbox(chave_reg[23:16]), sbox(chave_reg[15:8]), sbox(chave_reg[7:0]),
              sbox(chave_reg[31:24])} ^ {rcon(contador), 24'h000000};
  assign k0 = chave_reg[127:96] ^ t;
  assign k1 = chave_reg[95:64]  ^ k0;
  assign k2 = chave_reg[63:32]  ^ k1;
  assign k3 = chave_reg[31:0]   ^ k2;
  assign chave_nova = {k0, k1, k2, k3};

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int unsigned i = 0; i < 16; i++)
      sb[127-8*i -: 8] = sbox(estado_reg[127-8*i -: 8]);
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int unsigned c = 0; c < 4; c++)
      mc[127-32*c -: 32] = mixcol(sr[127-32*c -: 32]);
  end

  assign rodada_nova = ((contador == 4'(ROUNDS)) ? sr : mc) ^ chave_nova;

`ifdef RODADA_PARCIAL_EN
  assign alvo_ent = (bus.rodada == 4'd0 || bus.rodada > 4'(ROUNDS)) ? 4'(ROUNDS) : bus.rodada;
`else
  assign alvo_ent = 4'(ROUNDS);
`endif

  assign aceita = (estado == OCIOSO) && bus.ent_valido;
  assign ultima = (contador == alvo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (bus.ent_valido) estado_prox = RODANDO;
      RODANDO: if (ultima)         estado_prox = PRONTO;
      PRONTO:  if (bus.sai_pronto) estado_prox = OCIOSO;
      default:                     estado_prox = OCIOSO;
    endcase
  end

  always_comb begin
    bus.ent_pronto = (estado == OCIOSO);
    bus.sai_valido = (estado == PRONTO);
    bus.ocupado    = (estado != OCIOSO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_reg <= '0;
      chave_reg  <= '0;
      saida_reg  <= '0;
      contador   <= '0;
      alvo       <= '0;
    end else if (aceita) begin
      estado_reg <= bus.bloco ^ bus.chave;
      chave_reg  <= bus.chave;
      contador   <= 4'd1;
      alvo       <= alvo_ent;
    end else if (estado == RODANDO) begin
      estado_reg <= rodada_nova;
      chave_reg  <= chave_nova;
      contador   <= contador + 4'd1;
      if (ultima) saida_reg <= rodada_nova;
    end
  end

  assign bus.saida = saida_reg;

endmodule
